seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 16, SHALL set the datapath width; it SHALL be a power of two and at least 8.
REQ-003 Parameter SHW, default log2(WIDTH), SHALL set the width of the shift-amount field.
REQ-004 ClockInput  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 ResetInput  in  1  synchronous active-high reset, with priority over all other inputs.
REQ-006 Enable  in  1  global advance; when low, all state SHALL hold, including the multiply iteration.
REQ-007 Start  in  1  request for an operation; it SHALL be sampled only when Enable=1 and Busy=0.
REQ-008 OpCode  in  4  operation select (REQ-013).
REQ-009 OperandSelect  in  2  second operand: 0 = Bus_B, 1 = +1, 2 = all-ones (-1), 3 = 0.
REQ-010 UpdateFlag, UpdateResult  in  1 each  write enables, captured at Start and applied at completion.
REQ-011 Bus_A, Bus_B  in  WIDTH each  operands.
REQ-012 Outputs:
- Busy  out  1  high while a multiply iterates.
- Done  out  1  one-cycle completion pulse.
- Read_T1  out  WIDTH  result, or low half of the product.
- Read_T2  out  WIDTH  high half of the product.
- Read_Flag  out  4  flags {V,C,N,Z}, bit 3 down to bit 0.

Function
REQ-013 Opcodes SHALL be:
- 0000 ADD, 0001 SUB (A-B), 0100 AND, 0101 OR, 0110 XOR;
- 1000 SHL, 1001 SHR (logical), 1010 SAR;
- 1011 MUL (unsigned).
Every other code SHALL execute as ADD.
REQ-014 The block SHALL have two states, IDLE and MUL_RUN.
REQ-015 Single-cycle ops: Start accepted in IDLE at edge k SHALL write results at edge k; Done=1 for the following cycle only; Busy SHALL stay 0.
REQ-016 MUL: Start accepted at edge k SHALL latch A, the second operand, UpdateFlag and UpdateResult, and enter MUL_RUN.
REQ-017 The multiply SHALL use shift-add, one iteration per enabled cycle.
REQ-018 The multiply SHALL write results and return to IDLE at edge k+WIDTH (Enable held high).
REQ-019 Done SHALL be 1 for the following cycle; Busy SHALL be 1 for the cycles after edges k through k+WIDTH-1.
REQ-020 Start while Busy=1 SHALL be ignored, with no queuing.
REQ-021 Enable=0 for n cycles during MUL_RUN SHALL delay completion by exactly n cycles, with no corruption.
REQ-022 Result writes: if UpdateResult=1, Read_T1 SHALL take the result (the low half for MUL) and Read_T2 SHALL take the high half for MUL. For non-MUL ops Read_T2 SHALL hold.
REQ-023 Flag writes: if UpdateFlag=1, Read_Flag SHALL be written per REQ-024 to REQ-027; otherwise results and flags SHALL hold, while Done still pulses.
REQ-024 Z = result==0 (for MUL, the full 2*WIDTH product); N = result MSB (for MUL, product bit 2*WIDTH-1).
REQ-025 ADD: C = carry-out; V = signed overflow.
REQ-026 SUB: C = borrow (A<B unsigned); V = signed overflow.
REQ-027 Logic ops and MUL: C=0, V=0.
REQ-028 Shifts: amount = SecondOperand[SHW-1:0]; C = last bit shifted out (C=0 when amount=0); V=0.
REQ-029 All arithmetic SHALL wrap modulo 2^WIDTH, except MUL, which is exact over 2*WIDTH bits.
REQ-030 Done SHALL never be high for two consecutive cycles from one Start.

Reset
REQ-031 ResetInput=1 at an edge SHALL force:
- state IDLE; Busy=0, Done=0;
- Read_T1=0, Read_T2=0, Read_Flag=0;
- multiply internals cleared.
REQ-032 Reset during MUL_RUN SHALL abort the multiply; no Done and no result write SHALL follow.
REQ-033 Reset SHALL take effect regardless of Enable; Start coincident with reset SHALL be dropped.

Verification (WIDTH=16)
REQ-034 ADD, A=0x7FFF, OperandSelect=1, both updates -> Read_T1=0x8000, Read_Flag=1010, Done one cycle, Busy=0.
REQ-035 SUB, A=0x0001, OperandSelect=1 -> Read_T1=0x0000, Read_Flag=0001; then SUB A=0, B=1 -> Read_T1=0xFFFF, Read_Flag=0110.
REQ-036 MUL, A=B=0xFFFF, Enable high, Start at edge 0 -> Busy high after edges 0-15; results at edge 16: Read_T2=0xFFFE, Read_T1=0x0001, Read_Flag=0010; Done high one cycle; Start pulses issued while Busy ignored.
REQ-037 MUL 3*5 with Enable low 3 cycles mid-run -> Done after edge 19; Read_T1=0x000F, Read_T2=0x0000.
REQ-038 SHR A=0x8001, OperandSelect=1 -> Read_T1=0x4000, C=1; SAR A=0x8000 by 15 via Bus_B -> 0xFFFF, N=1.
REQ-039 Reset asserted after 5 MUL iterations -> next cycle Busy=0, Read_T1=Read_T2=0, Read_Flag=0; no Done afterwards.

Source files
------------

// File: rtl/seq_alu_if.sv
// Operand/result bus for seq_alu: control and operands in, handshake and results out.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 16
);
  logic             Enable;
  logic             Start;
  logic [3:0]       OpCode;
  logic [1:0]       OperandSelect;
  logic             UpdateFlag;
  logic             UpdateResult;
  logic [WIDTH-1:0] Bus_A;
  logic [WIDTH-1:0] Bus_B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Read_T1;
  logic [WIDTH-1:0] Read_T2;
  logic [3:0]       Read_Flag;

  modport master (
    output Enable, Start, OpCode, OperandSelect, UpdateFlag, UpdateResult, Bus_A, Bus_B,
    input  Busy, Done, Read_T1, Read_T2, Read_Flag
  );

  modport slave (
    input  Enable, Start, OpCode, OperandSelect, UpdateFlag, UpdateResult, Bus_A, Bus_B,
    output Busy, Done, Read_T1, Read_T2, Read_Flag
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops plus an iterative shift-add
// unsigned multiply producing a 2*WIDTH product over WIDTH enabled cycles.
module seq_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic     ClockInput,
  input logic     ResetInput,
  seq_alu_if.slave aluBus
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001,
    OP_AND = 4'b0100, OP_OR  = 4'b0101, OP_XOR = 4'b0110,
    OP_SHL = 4'b1000, OP_SHR = 4'b1001, OP_SAR = 4'b1010,
    OP_MUL = 4'b1011
  } opCode_t;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t             state, nextState;
  logic [WIDTH-1:0]   opA, opB, aluRes, mulCand, mulAddend;
  logic [WIDTH:0]     addTmp, subTmp, shlTmp, shrTmp, sarTmp, mulSum;
  logic [SHW-1:0]     shAmt, mulCount;
  logic [2*WIDTH-1:0] mulProd, mulNext;
  logic               aluC, aluV, isMul, accept, mulLast, latUpdFlag, latUpdRes, doneReg;
  logic [3:0]         aluFlags, mulFlags, flagReg;
  logic [WIDTH-1:0]   t1Reg, t2Reg;

  assign opA    = aluBus.Bus_A;
  assign shAmt  = opB[SHW-1:0];
  assign isMul  = (aluBus.OpCode == OP_MUL);
  assign accept = aluBus.Enable && (state == IDLE) && aluBus.Start;

  always_comb begin
    case (aluBus.OperandSelect)
      2'd0:    opB = aluBus.Bus_B;
      2'd1:    opB = WIDTH'(1);
      2'd2:    opB = '1;
      default: opB = '0;
    endcase
  end

  // Widened temporaries carry the shifted-out bit / carry in their extra position.
  always_comb begin
    addTmp = {1'b0, opA} + {1'b0, opB};
    subTmp = {1'b0, opA} - {1'b0, opB};
    shlTmp = {1'b0, opA} << shAmt;
    shrTmp = {opA, 1'b0} >> shAmt;
    sarTmp = $signed({opA, 1'b0}) >>> shAmt;
    aluRes = addTmp[WIDTH-1:0];
    aluC   = addTmp[WIDTH];
    aluV   = (opA[WIDTH-1] == opB[WIDTH-1]) && (addTmp[WIDTH-1] != opA[WIDTH-1]);
    case (aluBus.OpCode)
      OP_SUB: begin
        aluRes = subTmp[WIDTH-1:0];
        aluC   = subTmp[WIDTH];
        aluV   = (opA[WIDTH-1] != opB[WIDTH-1]) && (subTmp[WIDTH-1] != opA[WIDTH-1]);
      end
      OP_AND: begin aluRes = opA & opB; aluC = 1'b0; aluV = 1'b0; end
      OP_OR:  begin aluRes = opA | opB; aluC = 1'b0; aluV = 1'b0; end
      OP_XOR: begin aluRes = opA ^ opB; aluC = 1'b0; aluV = 1'b0; end
      OP_SHL: begin aluRes = shlTmp[WIDTH-1:0]; aluC = shlTmp[WIDTH]; aluV = 1'b0; end
      OP_SHR: begin aluRes = shrTmp[WIDTH:1];   aluC = shrTmp[0];     aluV = 1'b0; end
      OP_SAR: begin aluRes = sarTmp[WIDTH:1];   aluC = sarTmp[0];     aluV = 1'b0; end
      default: ;
    endcase
    aluFlags = {aluV, aluC, aluRes[WIDTH-1], (aluRes == '0)};
  end

  // One shift-add step: low half holds the remaining multiplier bits.
  always_comb begin
    mulAddend = mulProd[0] ? mulCand : '0;
    mulSum    = {1'b0, mulProd[2*WIDTH-1:WIDTH]} + {1'b0, mulAddend};
    mulNext   = {mulSum, mulProd[WIDTH-1:1]};
    mulFlags  = {2'b00, mulNext[2*WIDTH-1], (mulNext == '0)};
    mulLast   = (mulCount == SHW'(WIDTH - 1));
  end

  always_comb begin
    nextState = state;
    if (aluBus.Enable) begin
      case (state)
        IDLE:    if (aluBus.Start && isMul) nextState = MUL_RUN;
        MUL_RUN: if (mulLast) nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge ClockInput) begin
    if (ResetInput) state <= IDLE;
    else            state <= nextState;
  end

  always_ff @(posedge ClockInput) begin
    if (ResetInput) begin
      doneReg    <= 1'b0;
      t1Reg      <= '0;
      t2Reg      <= '0;
      flagReg    <= '0;
      mulProd    <= '0;
      mulCand    <= '0;
      mulCount   <= '0;
      latUpdFlag <= 1'b0;
      latUpdRes  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      if (accept && isMul) begin
        mulCand    <= opA;
        mulProd    <= {{WIDTH{1'b0}}, opB};
        mulCount   <= '0;
        latUpdFlag <= aluBus.UpdateFlag;
        latUpdRes  <= aluBus.UpdateResult;
      end else if (accept) begin
        doneReg <= 1'b1;
        if (aluBus.UpdateResult) t1Reg   <= aluRes;
        if (aluBus.UpdateFlag)   flagReg <= aluFlags;
      end else if (aluBus.Enable && state == MUL_RUN) begin
        mulProd  <= mulNext;
        mulCount <= mulCount + 1'b1;
        if (mulLast) begin
          doneReg <= 1'b1;
          if (latUpdRes) begin
            t1Reg <= mulNext[WIDTH-1:0];
            t2Reg <= mulNext[2*WIDTH-1:WIDTH];
          end
          if (latUpdFlag) flagReg <= mulFlags;
        end
      end
    end
  end

  assign aluBus.Busy      = (state == MUL_RUN);
  assign aluBus.Done      = doneReg;
  assign aluBus.Read_T1   = t1Reg;
  assign aluBus.Read_T2   = t2Reg;
  assign aluBus.Read_Flag = flagReg;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_seq_alu;
  localparam int unsigned W     = 16;
  localparam int unsigned MASK  = (1 << W) - 1;
  localparam longint      SMAX  = (longint'(1) << (W - 1)) - 1;
  localparam longint      SMIN  = -(longint'(1) << (W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.ClockInput(clk), .ResetInput(rst), .aluBus(bus));

  int checks = 0;
  int errors = 0;
  bit checkOn = 1'b0;

  // Reference model state
  bit              mBusy, mDone, mUF, mUR;
  int              mRemain;
  int unsigned     mA, mB, mT1, mT2;
  logic [3:0]      mFlag;
  longint unsigned mProd;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int unsigned x);
    return (x >= (32'd1 << (W - 1))) ? int'(x) - int'(32'd1 << W) : int'(x);
  endfunction

  function automatic int unsigned secondOp(input int unsigned sel, input int unsigned b);
    case (sel)
      0:       return b;
      1:       return 1;
      2:       return MASK;
      default: return 0;
    endcase
  endfunction

  function automatic void aluModel(input int unsigned op, input int unsigned a, input int unsigned b,
                                   output int unsigned r, output logic [3:0] f);
    int unsigned amt;
    longint      sd;
    longint unsigned sum;
    bit c, v;
    amt = b & (W - 1);
    c = 0;
    v = 0;
    case (op)
      1: begin
        r  = (a - b) & MASK;
        c  = a < b;
        sd = longint'(sx(a)) - longint'(sx(b));
        v  = (sd > SMAX) || (sd < SMIN);
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      8: begin
        r = (a << amt) & MASK;
        c = (amt != 0) && (((a >> (W - amt)) & 1) == 1);
      end
      9: begin
        r = a >> amt;
        c = (amt != 0) && (((a >> (amt - 1)) & 1) == 1);
      end
      10: begin
        r = int'(sx(a) >>> amt) & MASK;
        c = (amt != 0) && (((a >> (amt - 1)) & 1) == 1);
      end
      default: begin
        sum = longint'(a) + longint'(b);
        r   = int'(sum) & MASK;
        c   = (sum >> W) != 0;
        sd  = longint'(sx(a)) + longint'(sx(b));
        v   = (sd > SMAX) || (sd < SMIN);
      end
    endcase
    f = {v, c, (((r >> (W - 1)) & 1) == 1), (r == 0)};
  endfunction

  // Model advances on every rising edge from the inputs the bench is holding.
  initial begin
    int unsigned op, a, b, r;
    logic [3:0] f;
    forever begin
      @(posedge clk);
      if (rst) begin
        mBusy = 0; mDone = 0; mRemain = 0; mT1 = 0; mT2 = 0; mFlag = '0;
      end else begin
        mDone = 0;
        if (bus.Enable) begin
          if (mBusy) begin
            mRemain--;
            if (mRemain == 0) begin
              mProd = longint'(mA) * longint'(mB);
              mBusy = 0;
              mDone = 1;
              if (mUR) begin
                mT1 = int'(mProd) & MASK;
                mT2 = int'(mProd >> W) & MASK;
              end
              if (mUF) mFlag = {2'b00, mProd[2*W-1], (mProd == 0)};
            end
          end else if (bus.Start) begin
            op = bus.OpCode;
            a  = bus.Bus_A;
            b  = secondOp(bus.OperandSelect, bus.Bus_B);
            if (op == 11) begin
              mBusy = 1; mRemain = W; mA = a; mB = b;
              mUF = bus.UpdateFlag; mUR = bus.UpdateResult;
            end else begin
              aluModel(op, a, b, r, f);
              mDone = 1;
              if (bus.UpdateResult) mT1 = r;
              if (bus.UpdateFlag)   mFlag = f;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      check("busy", bus.Busy, mBusy);
      check("done", bus.Done, mDone);
      check("t1", bus.Read_T1, mT1);
      check("t2", bus.Read_T2, mT2);
      check("flag", bus.Read_Flag, mFlag);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] sel, input logic uf, input logic ur);
    bus.Enable = 1; bus.Start = 1; bus.OpCode = op; bus.Bus_A = a; bus.Bus_B = b;
    bus.OperandSelect = sel; bus.UpdateFlag = uf; bus.UpdateResult = ur;
    @(negedge clk);
    bus.Start = 0;
  endtask

  initial begin
    bus.Enable = 0; bus.Start = 0; bus.OpCode = '0; bus.OperandSelect = '0;
    bus.UpdateFlag = 0; bus.UpdateResult = 0; bus.Bus_A = '0; bus.Bus_B = '0;
    rst = 1;
    repeat (2) @(negedge clk);
    checkOn = 1;
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_t1", bus.Read_T1, 0);
    check("rst_t2", bus.Read_T2, 0);
    check("rst_flag", bus.Read_Flag, 0);
    rst = 0;
    @(negedge clk);

    issue(4'b0000, 16'h7FFF, 16'h0000, 2'd1, 1, 1);
    check("add_t1", bus.Read_T1, 16'h8000);
    check("add_flag", bus.Read_Flag, 4'b1010);
    check("add_done", bus.Done, 1);
    check("add_busy", bus.Busy, 0);
    @(negedge clk);
    check("add_done_drop", bus.Done, 0);

    issue(4'b0001, 16'h0001, 16'h0000, 2'd1, 1, 1);
    check("sub1_t1", bus.Read_T1, 16'h0000);
    check("sub1_flag", bus.Read_Flag, 4'b0001);
    issue(4'b0001, 16'h0000, 16'h0001, 2'd0, 1, 1);
    check("sub2_t1", bus.Read_T1, 16'hFFFF);
    check("sub2_flag", bus.Read_Flag, 4'b0110);

    issue(4'b1011, 16'hFFFF, 16'hFFFF, 2'd0, 1, 1);
    check("mul_busy_e0", bus.Busy, 1);
    for (int i = 1; i < 16; i++) begin
      bus.Start = 1; bus.OpCode = 4'b0000; bus.Bus_A = W'($urandom);
      @(negedge clk);
      check("mul_busy", bus.Busy, 1);
      check("mul_no_done", bus.Done, 0);
    end
    bus.Start = 0;
    @(negedge clk);
    check("mul_t2", bus.Read_T2, 16'hFFFE);
    check("mul_t1", bus.Read_T1, 16'h0001);
    check("mul_flag", bus.Read_Flag, 4'b0010);
    check("mul_done", bus.Done, 1);
    check("mul_idle", bus.Busy, 0);
    @(negedge clk);
    check("mul_done_drop", bus.Done, 0);

    issue(4'b1011, 16'h0003, 16'h0005, 2'd0, 1, 1);
    for (int e = 1; e <= 19; e++) begin
      bus.Enable = !(e >= 6 && e <= 8);
      @(negedge clk);
      if (e == 18) check("stall_early", bus.Done, 0);
    end
    check("stall_done", bus.Done, 1);
    check("stall_t1", bus.Read_T1, 16'h000F);
    check("stall_t2", bus.Read_T2, 16'h0000);
    @(negedge clk);

    issue(4'b1001, 16'h8001, 16'h0000, 2'd1, 1, 1);
    check("shr_t1", bus.Read_T1, 16'h4000);
    check("shr_flag", bus.Read_Flag, 4'b0100);
    issue(4'b1010, 16'h8000, 16'd15, 2'd0, 1, 1);
    check("sar_t1", bus.Read_T1, 16'hFFFF);
    check("sar_flag", bus.Read_Flag, 4'b0010);

    issue(4'b1011, 16'h1234, 16'h00FF, 2'd0, 1, 1);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_busy", bus.Busy, 0);
    check("abort_t1", bus.Read_T1, 0);
    check("abort_t2", bus.Read_T2, 0);
    check("abort_flag", bus.Read_Flag, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_no_done", bus.Done, 0);
    end

    for (int n = 0; n < 4000; n++) begin
      rst               = ($urandom_range(99) == 0);
      bus.Enable        = ($urandom_range(9) < 8);
      bus.Start         = $urandom_range(1);
      bus.OpCode        = ($urandom_range(3) == 0) ? 4'b1011 : 4'($urandom_range(15));
      bus.OperandSelect = 2'($urandom_range(3));
      bus.Bus_A         = W'($urandom);
      bus.Bus_B         = ($urandom_range(3) == 0) ? W'($urandom_range(W + 1)) : W'($urandom);
      bus.UpdateFlag    = ($urandom_range(3) != 0);
      bus.UpdateResult  = ($urandom_range(3) != 0);
      @(negedge clk);
    end
    rst = 0; bus.Start = 0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
